uart_tx_scheduler: RTL

//   Shares the single Uart8 transmitter between NUM_REQ byte requesters. Round-robin

---
 rtl/uart_tx_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one Uart8 transmitter between NUM_REQ byte requesters,
// issuing one byte per grant with a minimum inter-frame gap and a per-frame watchdog.
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 1250,
    parameter int TIMEOUT_CYCLES = 15000,
    parameter int CNT_W          = 16,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [ID_W-1:0]      grantId,
    output logic                 busy,
    output logic                 timeoutErr,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txData,
    input  logic                 txBusy,
    input  logic                 txDone
);

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 busy_q, busy_d;
    logic                 tx_en_q, tx_en_d;

    logic [7:0]           req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 win_found;
    logic [ID_W:0]        win_sum;
    logic [ID_W-1:0]      win_id;
    logic [7:0]           win_data;
    logic [ID_W:0]        ptr_inc;
    logic                 grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = reqData[8*gi +: 8];
        end
    endgenerate

    // Rotate so bit 0 is the channel the pointer currently favours.
    assign rot_valid = NUM_REQ'({reqValid, reqValid} >> ptr_q);

    always_comb begin
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && rot_valid[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, ptr_q} + (ID_W + 1)'(k);
            end
        end
        if (win_sum >= NUM_REQ_W) begin
            win_sum = win_sum - NUM_REQ_W;
        end
        win_id   = win_sum[ID_W-1:0];
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data = req_bytes[i];
            end
        end
    end

    assign grant   = (state_q == IDLE) && enable && !txBusy && win_found;
    assign ptr_inc = {1'b0, win_id} + 1'b1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= 8'h00;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            tx_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            tx_en_q       <= tx_en_d;
        end
    end

    // txDone wins over a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = SEND;
                cnt_d   = '0;
            end
            SEND: begin
                if (txDone || (cnt_q == TO_LAST)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = (state_q == SEND) && !txDone && (cnt_q == TO_LAST);
        if (grant) begin
            grant_id_d  = win_id;
            tx_data_d   = win_data;
            req_ready_d = NUM_REQ'(1) << win_id;
            tx_start_d  = 1'b1;
            ptr_d       = (ptr_inc == NUM_REQ_W) ? '0 : ptr_inc[ID_W-1:0];
        end
        busy_d  = (state_d != IDLE);
        tx_en_d = enable || (state_d != IDLE);
    end

    assign reqReady   = req_ready_q;
    assign grantId    = grant_id_q;
    assign busy       = busy_q;
    assign timeoutErr = timeout_err_q;
    assign txEn       = tx_en_q;
    assign txStart    = tx_start_q;
    assign txData     = tx_data_q;

endmodule
